// File: rtl/enemy_formation_ctrl.sv
// enemy_formation_ctrl: march/descend sequencer for the enemy row.
// Owns the formation origin, the march direction, the alive mask and
// the wave-cleared / invaded status levels consumed by the game FSM.
module enemy_formation_ctrl #(
   parameter int unsigned NUM_ENEMIES     = 8,
   parameter int unsigned ENEMY_W         = 50,
   parameter int unsigned SPACING         = 60,
   parameter int unsigned START_X         = 20,
   parameter int unsigned START_Y         = 40,
   parameter int unsigned LEFT_BOUND      = 0,
   parameter int unsigned RIGHT_BOUND     = 639,
   parameter int unsigned STEP_X          = 4,
   parameter int unsigned STEP_Y          = 10,
   parameter int unsigned FRAMES_PER_STEP = 2,
   parameter int unsigned INVADE_Y        = 400
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   frame_clk,
   input  logic                   start,
   input  logic                   is_playing,
   input  logic                   hit_valid,
   input  logic [3:0]             hit_index,
   output logic [9:0]             formation_x,
   output logic [9:0]             formation_y,
   output logic                   enemy_direction_X,
   output logic                   enemy_direction_Y,
   output logic [NUM_ENEMIES-1:0] alive,
   output logic [4:0]             alive_count,
   output logic                   delete_enemies,
   output logic                   wave_cleared,
   output logic                   invaded
);

   typedef enum logic [2:0] {
      BEFORE_GAME,
      MARCH,
      DESCEND,
      CLEARED,
      INVADED
   } state_t;

   localparam int unsigned     CNT_W     = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);
   localparam logic [9:0]      START_X_E = 10'(START_X);
   localparam logic [9:0]      START_Y_E = 10'(START_Y);
   localparam logic [9:0]      STEP_X_10 = 10'(STEP_X);
   localparam logic [10:0]     SPACING_E = 11'(SPACING);
   localparam logic [10:0]     WIDTH_M1  = 11'(ENEMY_W - 1);
   localparam logic [11:0]     STEP_X_12 = 12'(STEP_X);
   localparam logic [11:0]     RIGHT_E   = 12'(RIGHT_BOUND);
   localparam logic [11:0]     LEFT_LIM  = 12'(LEFT_BOUND + STEP_X);
   localparam logic [10:0]     STEP_Y_E  = 11'(STEP_Y);
   localparam logic [10:0]     INVADE_E  = 11'(INVADE_Y);
   localparam logic [4:0]      NUM_E     = 5'(NUM_ENEMIES);

   state_t                   state_q, state_d;
   logic [9:0]               x_q, x_d;
   logic [9:0]               y_q, y_d;
   logic                     dir_x_q, dir_x_d;
   logic                     dir_y_q, dir_y_d;
   logic [NUM_ENEMIES-1:0]   alive_q, alive_d;
   logic [4:0]               count_q, count_d;
   logic [CNT_W-1:0]         frame_cnt_q, frame_cnt_d;
   logic                     frame_prev_q;
   logic                     delete_q, delete_d;
   logic                     cleared_q, cleared_d;
   logic                     invaded_q, invaded_d;

   logic                     tick;
   logic                     active;
   logic                     step;
   logic                     hit_ok;
   logic [NUM_ENEMIES-1:0]   hit_mask;
   logic                     found;
   logic [3:0]               first_idx;
   logic [3:0]               last_idx;
   logic [10:0]              left_edge;
   logic [10:0]              right_edge;
   logic [10:0]              y_sum;

   assign tick   = frame_clk & ~frame_prev_q;
   assign active = is_playing & ((state_q == MARCH) | (state_q == DESCEND));

   // One-hot decode of the reported index; out-of-range indices match nothing.
   always_comb begin
      hit_mask = '0;
      for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
         hit_mask[i] = (hit_index == 4'(i));
      end
   end

   // Lowest and highest surviving enemy (pre-hit mask) for the edge checks.
   always_comb begin
      found     = 1'b0;
      first_idx = '0;
      last_idx  = '0;
      for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
         if (alive_q[i]) begin
            if (!found) begin
               first_idx = 4'(i);
            end
            found    = 1'b1;
            last_idx = 4'(i);
         end
      end
   end

   assign left_edge  = {1'b0, x_q} + 11'(first_idx) * SPACING_E;
   assign right_edge = {1'b0, x_q} + 11'(last_idx) * SPACING_E + WIDTH_M1;
   assign y_sum      = {1'b0, y_q} + STEP_Y_E;

   // Next-state logic: frame counter, hit bookkeeping, march/descend FSM.
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      dir_x_d     = dir_x_q;
      dir_y_d     = dir_y_q;
      alive_d     = alive_q;
      count_d     = count_q;
      frame_cnt_d = frame_cnt_q;
      delete_d    = delete_q;
      cleared_d   = cleared_q;
      invaded_d   = invaded_q;
      step        = 1'b0;

      if (active && tick) begin
         if (frame_cnt_q == CNT_LAST) begin
            frame_cnt_d = '0;
            step        = 1'b1;
         end else begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
         end
      end

      hit_ok = active & hit_valid & (|(alive_q & hit_mask));
      if (hit_ok) begin
         alive_d = alive_q & ~hit_mask;
         count_d = count_q - 5'd1;
      end

      case (state_q)
         BEFORE_GAME: begin
            if (start) begin
               state_d  = MARCH;
               delete_d = 1'b0;
            end
         end
         MARCH, DESCEND: begin
            // Losing the last enemy wins over a step landing on the same edge.
            if (hit_ok && (count_q == 5'd1)) begin
               state_d   = CLEARED;
               cleared_d = 1'b1;
               delete_d  = 1'b1;
            end else if (step) begin
               if (state_q == MARCH) begin
                  if (dir_x_q ? (({1'b0, right_edge} + STEP_X_12) > RIGHT_E)
                              : ({1'b0, left_edge} < LEFT_LIM)) begin
                     state_d = DESCEND;
                     dir_y_d = 1'b1;
                  end else if (dir_x_q) begin
                     x_d = x_q + STEP_X_10;
                  end else begin
                     x_d = x_q - STEP_X_10;
                  end
               end else begin
                  y_d     = y_sum[9:0];
                  dir_x_d = ~dir_x_q;
                  dir_y_d = 1'b0;
                  if (y_sum >= INVADE_E) begin
                     state_d   = INVADED;
                     invaded_d = 1'b1;
                     delete_d  = 1'b1;
                  end else begin
                     state_d = MARCH;
                  end
               end
            end
         end
         CLEARED: begin
            if (start) begin
               state_d     = MARCH;
               x_d         = START_X_E;
               y_d         = START_Y_E;
               dir_x_d     = 1'b1;
               dir_y_d     = 1'b0;
               alive_d     = '1;
               count_d     = NUM_E;
               frame_cnt_d = '0;
               delete_d    = 1'b0;
               cleared_d   = 1'b0;
               invaded_d   = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // State registers; the frame_clk sample runs even while paused or in reset.
   always_ff @(posedge Clk) begin
      frame_prev_q <= frame_clk;
      if (Reset) begin
         state_q     <= BEFORE_GAME;
         x_q         <= START_X_E;
         y_q         <= START_Y_E;
         dir_x_q     <= 1'b1;
         dir_y_q     <= 1'b0;
         alive_q     <= '1;
         count_q     <= NUM_E;
         frame_cnt_q <= '0;
         delete_q    <= 1'b1;
         cleared_q   <= 1'b0;
         invaded_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         dir_x_q     <= dir_x_d;
         dir_y_q     <= dir_y_d;
         alive_q     <= alive_d;
         count_q     <= count_d;
         frame_cnt_q <= frame_cnt_d;
         delete_q    <= delete_d;
         cleared_q   <= cleared_d;
         invaded_q   <= invaded_d;
      end
   end

   assign formation_x       = x_q;
   assign formation_y       = y_q;
   assign enemy_direction_X = dir_x_q;
   assign enemy_direction_Y = dir_y_q;
   assign alive             = alive_q;
   assign alive_count       = count_q;
   assign delete_enemies    = delete_q;
   assign wave_cleared      = cleared_q;
   assign invaded           = invaded_q;

endmodule
